uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ byte streams share one UART
// transmitter. A requester's byte is captured into a single holding
// register. It is then offered to the transmitter until m_tready is high.
// While a byte is held, no other byte is accepted.
//
// Optional feature (macro ARB_TLAST_LOCK_EN): when the macro is defined,
// a requester keeps the arbiter locked until it sends a beat with s_tlast
// set. Its message is then never interleaved with other streams. When the
// macro is undefined, s_tlast is ignored and arbitration repeats after
// every byte.
//
// Ports:
//   clk, rst   rising-edge clock and synchronous active-high reset
//   s_tdata    requester bytes; requester i uses [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid   per-requester byte valid
//   s_tlast    per-requester end-of-message flag (used only with the lock)
//   s_tready   per-requester accept, one-hot or zero
//   m_tdata    held byte towards the transmitter
//   m_tvalid   held byte valid
//   m_tready   transmitter accept
//   grant_id   requester that owns the held byte or the lock
//   busy       holding register full or lock held
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [2:0]                    grant_id,
  output logic                          busy
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_HOLD = 1'b1;

  logic                  state_r;
  logic                  state_next_s;
  logic [DATA_WIDTH-1:0] hold_data_r;
  logic [2:0]            grant_id_r;
  logic [2:0]            last_grant_r;
  logic                  lock_active_s;
  logic [7:0]            valid_pad_s;
  logic [3:0]            scan_idx_s;
  logic                  cand_s;
  logic [2:0]            winner_s;
  logic                  found_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  handshake_s;

  // Round-robin search starting just after the last grant; the lock overrides it
  always_comb begin
    valid_pad_s = 8'h00;
    valid_pad_s[NUM_REQ-1:0] = s_tvalid;
    winner_s   = 3'd0;
    found_s    = 1'b0;
    scan_idx_s = 4'd0;
    cand_s     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx_s = {1'b0, last_grant_r} + 4'(k);
      // Wrap without a modulo operator so any NUM_REQ in 2..8 works
      scan_idx_s = (scan_idx_s >= 4'(NUM_REQ)) ? (scan_idx_s - 4'(NUM_REQ)) : scan_idx_s;
      cand_s     = valid_pad_s[scan_idx_s[2:0]] & ~found_s;
      winner_s   = cand_s ? scan_idx_s[2:0] : winner_s;
      found_s    = found_s | cand_s;
    end
    // A locked requester is the only candidate; others wait even if valid
    winner_s = lock_active_s ? last_grant_r : winner_s;
    found_s  = lock_active_s ? valid_pad_s[last_grant_r] : found_s;
  end

  // Select the winner's byte
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = (winner_s == 3'(i)) ? s_tdata[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STATE_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      STATE_IDLE: state_next_s = handshake_s ? STATE_HOLD : STATE_IDLE;
      STATE_HOLD: state_next_s = m_tready ? STATE_IDLE : STATE_HOLD;
      default:    state_next_s = STATE_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE, and never while reset is asserted
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_tready[i] = (state_r == STATE_IDLE) & ~rst & found_s & (winner_s == 3'(i));
    end
    handshake_s = |(s_tready & s_tvalid);
    m_tvalid    = (state_r == STATE_HOLD);
    busy        = (state_r == STATE_HOLD) | lock_active_s;
  end

  // Holding register, grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_r  <= '0;
      grant_id_r   <= 3'd0;
      last_grant_r <= 3'(NUM_REQ - 1);
    end else if (handshake_s) begin
      hold_data_r  <= sel_data_s;
      grant_id_r   <= winner_s;
      last_grant_r <= winner_s;
    end else begin
      hold_data_r  <= hold_data_r;
      grant_id_r   <= grant_id_r;
      last_grant_r <= last_grant_r;
    end
  end

`ifdef ARB_TLAST_LOCK_EN
  logic lock_active_r;
  logic sel_last_s;

  // End-of-message flag of the current winner
  always_comb begin
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_last_s = (winner_s == 3'(i)) ? s_tlast[i] : sel_last_s;
    end
  end

  // Lock is set by any accepted non-last beat and cleared by a last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active_r <= 1'b0;
    end else if (handshake_s) begin
      lock_active_r <= ~sel_last_s;
    end else begin
      lock_active_r <= lock_active_r;
    end
  end

  assign lock_active_s = lock_active_r;
`else
  logic unused_tlast_s;

  assign unused_tlast_s = ^s_tlast;
  assign lock_active_s  = 1'b0;
`endif

  assign m_tdata  = hold_data_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [2:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        mrdy;
    logic [3:0]  exp_rdy;
    logic        exp_mv;
    logic [7:0]  exp_md;
    logic [2:0]  exp_gid;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = 4'h0; s_tlast = 4'hF; m_tready = 1'b0; s_tdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] outq[$];
    logic [2:0] gidq[$];
    int idx;
    int cnt;

    rst = 1'b1; s_tdata = 32'h0; s_tvalid = 4'h0; s_tlast = 4'hF; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // rst vld data mrdy | rdy mv md gid busy
    vecs[0]  = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'h4, 32'h00550000, 1'b1, 4'h4, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 32'h00550000, 1'b1, 4'h0, 1'b1, 8'h55, 3'd2, 1'b1};
    vecs[3]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h8, 1'b0, 8'h55, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'hA3, 3'd3, 1'b1};
    vecs[5]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b0, 8'hA3, 3'd3, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0, 1'b1};
    vecs[7]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0, 1'b1};
    vecs[8]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'hA0, 3'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'h3, 32'hA3A2A1A0, 1'b1, 4'h2, 1'b0, 8'hA0, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'hA1, 3'd1, 1'b1};
    vecs[11] = '{1'b0, 4'h1, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b0, 8'hA1, 3'd1, 1'b0};
    vecs[12] = '{1'b1, 4'h1, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'hA0, 3'd0, 1'b1};
    vecs[13] = '{1'b0, 4'h0, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[14] = '{1'b0, 4'h8, 32'hA3A2A1A0, 1'b1, 4'h8, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'hA3, 3'd3, 1'b1};
    vecs[16] = '{1'b0, 4'h0, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b0, 8'hA3, 3'd3, 1'b0};

    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      rst = vecs[v].rst; s_tvalid = vecs[v].vld; s_tdata = vecs[v].data;
      s_tlast = 4'hF; m_tready = vecs[v].mrdy;
      #1;
      chk($sformatf("vec%0d s_tready", v), 32'(s_tready), 32'(vecs[v].exp_rdy));
      chk($sformatf("vec%0d m_tvalid", v), 32'(m_tvalid), 32'(vecs[v].exp_mv));
      chk($sformatf("vec%0d m_tdata", v),  32'(m_tdata),  32'(vecs[v].exp_md));
      chk($sformatf("vec%0d grant_id", v), 32'(grant_id), 32'(vecs[v].exp_gid));
      chk($sformatf("vec%0d busy", v),     32'(busy),     32'(vecs[v].exp_busy));
    end

    // Fairness: all valid, 8 bytes rotate 0,1,2,3,0,1,2,3
    do_reset();
    outq.delete(); gidq.delete();
    for (int c = 0; c < 40 && outq.size() < 8; c++) begin
      @(negedge clk);
      s_tvalid = 4'hF; s_tdata = 32'hA3A2A1A0; s_tlast = 4'hF; m_tready = 1'b1;
      #1;
      if (m_tvalid && m_tready) begin
        outq.push_back(m_tdata);
        gidq.push_back(grant_id);
      end
    end
    chk("fair count", 32'(outq.size()), 32'd8);
    for (int k = 0; k < outq.size(); k++) begin
      chk($sformatf("fair byte%0d", k), 32'(outq[k]), 32'(8'hA0 + 8'(k % 4)));
      chk($sformatf("fair gid%0d", k), 32'(gidq[k]), 32'(k % 4));
    end

    // Backpressure: hold 0xA3 for 100 cycles, then exactly one transfer
    do_reset();
    @(negedge clk);
    s_tvalid = 4'h8; s_tdata = 32'hA3A2A1A0; m_tready = 1'b0;
    #1;
    chk("bp accept", 32'(s_tready), 32'h8);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      s_tvalid = 4'hF; m_tready = 1'b0;
      #1;
      chk("bp m_tvalid", 32'(m_tvalid), 32'd1);
      chk("bp m_tdata", 32'(m_tdata), 32'hA3);
      chk("bp grant_id", 32'(grant_id), 32'd3);
      chk("bp s_tready", 32'(s_tready), 32'h0);
    end
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_tvalid = 4'h0; m_tready = 1'b1;
      #1;
      if (m_tvalid && m_tready && m_tdata == 8'hA3) cnt++;
    end
    chk("bp transfers", 32'(cnt), 32'd1);

    // Reset while holding 0x7E
    do_reset();
    @(negedge clk);
    s_tvalid = 4'h4; s_tdata = 32'h007E0000; m_tready = 1'b0;
    #1;
    chk("rh accept", 32'(s_tready), 32'h4);
    @(negedge clk);
    s_tvalid = 4'h0;
    #1;
    chk("rh held", 32'(m_tdata), 32'h7E);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_tvalid = 4'hA; s_tdata = 32'hA3A2A1A0; m_tready = 1'b1;
    #1;
    chk("rh m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rh grant", 32'(s_tready), 32'h2);
    cnt = 0; outq.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      s_tvalid = 4'h0;
      #1;
      if (m_tvalid && m_tdata == 8'h7E) cnt++;
      if (m_tvalid && m_tready) outq.push_back(m_tdata);
    end
    chk("rh no 7E", 32'(cnt), 32'd0);
    chk("rh out count", 32'(outq.size()), 32'd1);
    if (outq.size() > 0) chk("rh first byte", 32'(outq[0]), 32'hA1);

    // Lock: requester 1 sends 0x10,0x11,0x12 (last on 0x12), requester 0 valid
    do_reset();
    idx = 0; outq.delete();
    for (int c = 0; c < 40 && outq.size() < 4; c++) begin
      @(negedge clk);
      s_tvalid = {2'b00, (idx < 3), (c > 0)};
      s_tdata  = {16'h0000, 8'h10 + 8'(idx), 8'h20};
      s_tlast  = {2'b00, (idx == 2), 1'b1};
      m_tready = 1'b1;
      #1;
      if (s_tready[1] && s_tvalid[1]) idx++;
      if (m_tvalid && m_tready) outq.push_back(m_tdata);
    end
    chk("lock count", 32'(outq.size()), 32'd4);
`ifdef ARB_TLAST_LOCK_EN
    if (outq.size() == 4) begin
      chk("lock b0", 32'(outq[0]), 32'h10);
      chk("lock b1", 32'(outq[1]), 32'h11);
      chk("lock b2", 32'(outq[2]), 32'h12);
      chk("lock b3", 32'(outq[3]), 32'h20);
    end
    // Locked requester goes idle: nobody else gets in
    do_reset();
    @(negedge clk);
    s_tvalid = 4'h2; s_tdata = 32'h00001020; s_tlast = 4'h1; m_tready = 1'b1;
    #1;
    chk("lockhold accept", 32'(s_tready), 32'h2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_tvalid = 4'h1;
      #1;
      chk("lockhold s_tready", 32'(s_tready), 32'h0);
      chk("lockhold busy", 32'(busy), 32'd1);
    end
`else
    if (outq.size() == 4) begin
      chk("ilv b0", 32'(outq[0]), 32'h10);
      chk("ilv b1", 32'(outq[1]), 32'h20);
      chk("ilv b2", 32'(outq[2]), 32'h11);
      chk("ilv b3", 32'(outq[3]), 32'h20);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
